// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code assembler: folds E0/F0 prefixes into flags on the following code
// and queues {ext, brk, code} entries in a small first-word-fall-through FIFO.
module ps2_scan_ctrl #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  input  logic       rd_en,
  output logic       code_valid,
  output logic [7:0] code_out,
  output logic       is_ext,
  output logic       is_break,
  output logic [4:0] level,
  output logic       overflow,
  output logic [7:0] disp_byte
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          push_req;
  logic          ext_nxt, brk_nxt;

  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [4:0]    cnt;
  logic          full, pop, push;

  assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A new byte always wins over an expiring prefix in the same cycle.
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    ext_nxt   = 1'b0;
    brk_nxt   = 1'b0;
    if (data_valid) begin
      if (data_in == PFX_EXT) begin
        state_nxt = GOT_E0;
      end else if (data_in == PFX_BRK) begin
        case (state)
          IDLE, GOT_F0: state_nxt = GOT_F0;
          default:      state_nxt = GOT_E0F0;
        endcase
      end else begin
        push_req  = 1'b1;
        ext_nxt   = (state == GOT_E0) || (state == GOT_E0F0);
        brk_nxt   = (state == GOT_F0) || (state == GOT_E0F0);
        state_nxt = IDLE;
      end
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                tcnt <= '0;
    else if (data_valid || state == IDLE)   tcnt <= '0;
    else if (timeout)                       tcnt <= '0;
    else                                    tcnt <= tcnt + TW'(1);
  end

  assign full = (cnt == 5'(DEPTH));
  assign pop  = rd_en && (cnt != 5'd0);
  assign push = push_req && (!full || pop);

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wptr] <= {ext_nxt, brk_nxt, data_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= 5'd0;
      overflow  <= 1'b0;
      disp_byte <= 8'h00;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
      if (push_req) disp_byte <= data_in;
    end
  end

  assign code_valid = (cnt != 5'd0);
  assign level      = cnt;
  assign {is_ext, is_break, code_out} = mem[rptr];

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Randomized and directed bench for ps2_scan_ctrl against a queue-based prefix/FIFO model.
module tb_ps2_scan_ctrl;
  localparam int DEPTH = 4;
  localparam int T     = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rd_en = 1'b0;
  logic       code_valid;
  logic [7:0] code_out;
  logic       is_ext;
  logic       is_break;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] disp_byte;

  always #5 clk = ~clk;

  ps2_scan_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in), .rd_en(rd_en),
    .code_valid(code_valid), .code_out(code_out), .is_ext(is_ext), .is_break(is_break),
    .level(level), .overflow(overflow), .disp_byte(disp_byte)
  );

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  logic [9:0] mq[$];
  bit         m_ext, m_brk, m_over;
  logic [7:0] m_disp = 8'h00;
  int         cyc = 0;
  int         last_pfx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A prefix is just pending flags; E0 resets to ext-only, F0 adds brk.
  task automatic model(input bit rs, input bit dv, input logic [7:0] d, input bit rd);
    bit full, pop;
    cyc++;
    if (rs) begin
      mq.delete();
      m_ext = 0; m_brk = 0; m_over = 0; m_disp = 8'h00;
      return;
    end
    if ((m_ext || m_brk) && (cyc - last_pfx > T)) begin
      m_ext = 0; m_brk = 0;
    end
    full = (mq.size() == DEPTH);
    pop  = rd && (mq.size() != 0);
    if (pop) void'(mq.pop_front());
    if (dv) begin
      if (d == 8'hE0) begin
        m_ext = 1; m_brk = 0; last_pfx = cyc;
      end else if (d == 8'hF0) begin
        m_brk = 1; last_pfx = cyc;
      end else begin
        m_disp = d;
        if (!full || pop) mq.push_back({m_ext, m_brk, d});
        else m_over = 1;
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  task automatic step(input bit rs, input bit dv, input logic [7:0] d, input bit rd);
    rst = rs; data_valid = dv; data_in = d; rd_en = rd;
    @(posedge clk);
    model(rs, dv, d, rd);
    #1;
    rst = 0; data_valid = 0; rd_en = 0;
  endtask

  task automatic send(input logic [7:0] b);
    step(0, 1, b, 0);
  endtask

  task automatic pop1();
    step(0, 0, 8'h00, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h00, 0);
  endtask

  initial begin
    logic [9:0] head;
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("code_valid", 32'(code_valid), 32'(mq.size() != 0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_over));
        chk("disp_byte", 32'(disp_byte), 32'(m_disp));
        if (mq.size() != 0) begin
          head = mq[0];
          chk("code_out", 32'(code_out), 32'(head[7:0]));
          chk("is_ext", 32'(is_ext), 32'(head[9]));
          chk("is_break", 32'(is_break), 32'(head[8]));
        end
      end
    end
  end

  initial begin
    int dvp, rdp;
    bit rs, dv, rd;
    logic [7:0] b;

    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h55, 1);
    checking = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(code_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_disp", 32'(disp_byte), 0);

    send(8'h1C);
    chk("mk_valid", 32'(code_valid), 1);
    chk("mk_code", 32'(code_out), 32'h1C);
    chk("mk_flags", 32'({is_ext, is_break}), 0);
    chk("mk_level", 32'(level), 1);
    chk("mk_disp", 32'(disp_byte), 32'h1C);
    pop1();

    send(8'hE0); send(8'hF0); send(8'h75);
    chk("extbrk_code", 32'(code_out), 32'h75);
    chk("extbrk_flags", 32'({is_ext, is_break}), 32'b11);
    chk("extbrk_level", 32'(level), 1);
    pop1();

    send(8'hF0); idle(T); send(8'h1C);
    chk("tmo_flags", 32'({is_ext, is_break}), 0);
    chk("tmo_code", 32'(code_out), 32'h1C);
    pop1();
    send(8'hF0); idle(T - 1); send(8'h1C);
    chk("pre_tmo_flags", 32'({is_ext, is_break}), 32'b01);
    pop1();

    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("full_level", 32'(level), 4);
    chk("full_ovf", 32'(overflow), 1);
    chk("full_head", 32'(code_out), 1);
    chk("full_disp", 32'(disp_byte), 5);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_head", 32'(code_out), 32'(i));
      pop1();
    end
    chk("drain_empty", 32'(code_valid), 0);

    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) send(8'(8'h11 + i));
    step(0, 1, 8'h2A, 1);
    chk("pp_level", 32'(level), 4);
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_head", 32'(code_out), 32'h12);
    repeat (3) pop1();
    chk("pp_tail", 32'(code_out), 32'h2A);
    pop1();

    step(0, 1, 8'h3C, 1);
    chk("empty_pp_level", 32'(level), 1);
    chk("empty_pp_code", 32'(code_out), 32'h3C);

    step(1, 1, 8'h33, 1);
    chk("rst_dv_level", 32'(level), 0);
    chk("rst_dv_disp", 32'(disp_byte), 0);

    send(8'hE0); step(1, 0, 8'h00, 0); send(8'h1C);
    chk("rst_pfx_flags", 32'({is_ext, is_break}), 0);
    chk("rst_pfx_code", 32'(code_out), 32'h1C);
    chk("rst_pfx_level", 32'(level), 1);
    chk("rst_pfx_ovf", 32'(overflow), 0);
    pop1();

    dvp = 40; rdp = 30;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        dvp = $urandom_range(2, 80);
        rdp = $urandom_range(0, 70);
      end
      rs = ($urandom_range(0, 999) == 0);
      dv = ($urandom_range(0, 99) < dvp);
      rd = ($urandom_range(0, 99) < rdp);
      case ($urandom_range(0, 9))
        0, 1, 2: b = 8'hE0;
        3, 4:    b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      step(rs, dv, b, rd);
    end

    @(negedge clk);
    #1;
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_scan_ctrl.md
PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning scan-code FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, meaning prefix-state timeout in clk cycles.
REQ-003 SHALL use one clock and a synchronous, active-high reset:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
REQ-004 SHALL have these remaining ports:
- data_valid  input  1  one-cycle strobe from PS/2 receiver, data_in valid
- data_in  input  8  received PS/2 byte
- rd_en  input  1  consumer pop request
- code_valid  output  1  FIFO not empty, head entry valid
- code_out  output  8  scan code at FIFO head
- is_ext  output  1  head entry carried E0 prefix
- is_break  output  1  head entry carried F0 prefix (key release)
- level  output  5  current FIFO occupancy, 0..DEPTH
- overflow  output  1  sticky, entry dropped because FIFO full
- disp_byte  output  8  last scan code pushed, feeds 7-segment transcoders

Function
REQ-005 SHALL implement prefix FSM states IDLE, GOT_E0, GOT_F0, GOT_E0F0; transitions only on data_valid=1 or timeout.
REQ-006 IDLE: byte E0 -> GOT_E0; F0 -> GOT_F0; other -> push {ext=0,brk=0,code}, stay IDLE.
REQ-007 GOT_E0: F0 -> GOT_E0F0; E0 -> stay GOT_E0; other -> push {ext=1,brk=0}, -> IDLE.
REQ-008 GOT_F0: F0 -> stay GOT_F0; E0 -> GOT_E0 (prior F0 discarded); other -> push {ext=0,brk=1}, -> IDLE.
REQ-009 GOT_E0F0: E0 -> GOT_E0; F0 -> stay GOT_E0F0; other -> push {ext=1,brk=1}, -> IDLE.
REQ-010 SHALL hold a timeout counter, cleared on every data_valid and in IDLE; when it reaches TIMEOUT_CYC-1 in any prefix state, FSM -> IDLE next cycle with no push.
REQ-011 FIFO SHALL be first-word-fall-through, entries 10 bits {ext,brk,code[7:0]}; code_out/is_ext/is_break show head combinationally from storage.
REQ-012 Latency: byte completing a code at data_valid in cycle N SHALL be visible (code_valid=1 if previously empty, level incremented) in cycle N+1.
REQ-013 Pop SHALL occur on rd_en=1 with code_valid=1; head advances and level decrements next cycle; rd_en with FIFO empty SHALL be ignored.
REQ-014 Push when full without simultaneous pop SHALL drop the entry, leave FIFO unchanged, set overflow=1 until reset.
REQ-015 Simultaneous push and pop when full SHALL accept both; level stays DEPTH, no overflow.
REQ-016 Simultaneous push and rd_en when empty SHALL accept push only; level becomes 1.
REQ-017 Read/write pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; level SHALL never exceed DEPTH.
REQ-018 disp_byte SHALL update to the pushed code on every push attempt, including dropped ones.

Reset
REQ-019 rst=1 at a clock edge SHALL set FSM IDLE, timeout counter 0, pointers 0, level 0, code_valid 0, overflow 0, disp_byte 8'h00; code_out/is_ext/is_break don't-care while code_valid=0.
REQ-020 Reset mid-sequence (e.g. after E0 received) SHALL discard the prefix; next byte 1C after reset pushes {0,0,1C}.
REQ-021 data_valid and rd_en asserted in a reset cycle SHALL be ignored.

Verification
REQ-022 Bytes 1C -> code_valid=1, code_out=1C, is_ext=0, is_break=0, level=1, disp_byte=1C one cycle after strobe.
REQ-023 Bytes E0,F0,75 -> single entry code_out=75, is_ext=1, is_break=1; level=1 (prefixes not stored).
REQ-024 F0 then TIMEOUT_CYC idle cycles then 1C -> entry {0,0,1C} (prefix expired).
REQ-025 DEPTH+1 codes 01..05 (DEPTH=4), no reads -> level=4, overflow=1, head=01; pop four times -> 01,02,03,04, then code_valid=0.
REQ-026 FIFO full plus code 2A with rd_en same cycle -> level stays 4, overflow stays 0, 2A at tail.
REQ-027 E0 received, rst pulsed, then 1C -> entry {0,0,1C}, overflow=0, level=1.
